// File: rtl/vertex_sequencer.sv
// Frame-level vertex sequencer: latches a shape at frame start, snapshots the shape LUT,
// then streams its vertices downstream one per valid/ready handshake.
module vertex_sequencer #(
    parameter int MAX_VERTS = 12,
    parameter int VW        = 48
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    frame_start,
    input  logic [1:0]              shape_req,
    output logic [1:0]              lut_shapeselect,
    input  logic [MAX_VERTS*VW-1:0] lut_verts,
    input  logic [3:0]              lut_num,
    output logic                    vtx_valid,
    input  logic                    vtx_ready,
    output logic [VW-1:0]           vtx_data,
    output logic [3:0]              vtx_idx,
    output logic                    vtx_last,
    output logic                    busy,
    output logic                    frame_done,
    output logic [1:0]              shape_active
);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  shape_q;
    logic        pend_q;
    logic [1:0]  pend_shape_q;
    logic [3:0]  n_q;
    logic [3:0]  idx_q;
    logic [3:0]  num_clamp;
    logic [VW-1:0] snap [MAX_VERTS];

    assign num_clamp = (lut_num > 4'(MAX_VERTS)) ? 4'(MAX_VERTS) : lut_num;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_start) state_d = LOAD;
            LOAD:    state_d = (num_clamp == 4'd0) ? DONE : STREAM;
            STREAM:  if (vtx_ready && vtx_last) state_d = DONE;
            DONE:    state_d = (pend_q || frame_start) ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            shape_q      <= 2'd0;
            pend_q       <= 1'b0;
            pend_shape_q <= 2'd0;
            n_q          <= 4'd0;
            idx_q        <= 4'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (frame_start) shape_q <= shape_req;
                LOAD: begin
                    n_q   <= num_clamp;
                    idx_q <= 4'd0;
                end
                STREAM: if (vtx_ready && !vtx_last) idx_q <= idx_q + 4'd1;
                DONE: begin
                    // A request arriving in this very cycle is the newest one, so it wins.
                    if (frame_start)  shape_q <= shape_req;
                    else if (pend_q)  shape_q <= pend_shape_q;
                    pend_q <= 1'b0;
                end
                default: ;
            endcase
            if (frame_start && (state_q == LOAD || state_q == STREAM)) begin
                pend_q       <= 1'b1;
                pend_shape_q <= shape_req;
            end
        end
    end

    // NOTE: the snapshot is plain storage and deliberately has no reset; it is only read after a LOAD.
    always_ff @(posedge clk) begin
        if (state_q == LOAD) begin
            for (int k = 0; k < MAX_VERTS; k++) begin
                snap[k] <= lut_verts[k*VW +: VW];
            end
        end
    end

    assign vtx_valid       = (state_q == STREAM);
    assign vtx_data        = vtx_valid ? snap[idx_q] : '0;
    assign vtx_idx         = idx_q;
    assign vtx_last        = vtx_valid && (idx_q == n_q - 4'd1);
    assign busy            = (state_q != IDLE);
    assign frame_done      = (state_q == DONE);
    assign shape_active    = shape_q;
    assign lut_shapeselect = shape_q;

endmodule
